// File: rtl/encoder_pkg.sv
// Shared encoder constants and derived beat geometry for the parity serializer.
package encoder_pkg;

    localparam int EGF_DIM     = 8;   // bits per GF symbol
    localparam int RSC_PAR_LEN = 16;  // parity symbols per codeword
    localparam int ENC_SYM     = 3;   // symbols per output beat
    localparam int PRO_PHASE   = 0;   // phase offset of the upstream parity processor

    // Beats needed to carry len symbols es at a time.
    function automatic int nb_of(input int len, input int es);
        return (len + es - 1) / es;
    endfunction

    // Valid symbols in the final (possibly partial) beat.
    function automatic int last_cnt_of(input int len, input int es);
        return len - (nb_of(len, es) - 1) * es;
    endfunction

    // Beat index width; at least one bit even for a single-beat codeword.
    function automatic int bidx_w_of(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    localparam int NB       = nb_of(RSC_PAR_LEN, ENC_SYM);
    localparam int LAST_CNT = last_cnt_of(RSC_PAR_LEN, ENC_SYM);
    localparam int BIDX_W   = bidx_w_of(NB);

endpackage

// File: rtl/enc_par_beat_sel.sv
// Combinational beat slicer: picks the symbols of beat beat_idx out of a
// parity vector, highest-order symbol first, earliest symbol in the top slot.
module enc_par_beat_sel #(
    parameter int EGF_DIM     = encoder_pkg::EGF_DIM,
    parameter int RSC_PAR_LEN = encoder_pkg::RSC_PAR_LEN,
    parameter int ENC_SYM     = encoder_pkg::ENC_SYM,
    parameter int BIDX_W      = encoder_pkg::BIDX_W
) (
    input  logic [RSC_PAR_LEN*EGF_DIM-1:0] vec,
    input  logic [BIDX_W-1:0]              beat_idx,
    output logic [ENC_SYM*EGF_DIM-1:0]     data,
    output logic [$clog2(ENC_SYM+1)-1:0]   cnt,
    output logic                           last
);
    import encoder_pkg::*;

    localparam int CNT_W = $clog2(ENC_SYM + 1);
    localparam int NBEATS = nb_of(RSC_PAR_LEN, ENC_SYM);
    localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ENC_SYM);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(last_cnt_of(RSC_PAR_LEN, ENC_SYM));

    // Slot s maps to symbol top - k*ENC_SYM - (ENC_SYM-1-s); slots below symbol 0 read as zero.
    always_comb begin
        int idx;
        idx  = 0;
        data = '0;
        for (int s = 0; s < ENC_SYM; s++) begin
            idx = RSC_PAR_LEN - 1 - int'(beat_idx) * ENC_SYM - (ENC_SYM - 1 - s);
            if (idx >= 0 && idx < RSC_PAR_LEN)
                data[s*EGF_DIM +: EGF_DIM] = vec[idx*EGF_DIM +: EGF_DIM];
        end
        last = (beat_idx == LAST_IDX);
        cnt  = last ? CNT_LAST : CNT_FULL;
    end

endmodule

// File: rtl/enc_par_serializer.sv
// Two-entry ping-pong parity buffer feeding an ENC_SYM-wide beat stream.
module enc_par_serializer #(
    parameter int EGF_DIM     = encoder_pkg::EGF_DIM,
    parameter int RSC_PAR_LEN = encoder_pkg::RSC_PAR_LEN,
    parameter int ENC_SYM     = encoder_pkg::ENC_SYM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           par_in_valid,
    output logic                           par_in_ready,
    input  logic [RSC_PAR_LEN*EGF_DIM-1:0] par_in_data,
    output logic                           par_out_valid,
    input  logic                           par_out_ready,
    output logic [ENC_SYM*EGF_DIM-1:0]     par_out_data,
    output logic [$clog2(ENC_SYM+1)-1:0]   par_out_cnt,
    output logic                           par_out_last
);
    import encoder_pkg::*;

    localparam int VEC_W  = RSC_PAR_LEN * EGF_DIM;
    localparam int BEAT_W = ENC_SYM * EGF_DIM;
    localparam int CNT_W  = $clog2(ENC_SYM + 1);
    localparam int NBEATS = nb_of(RSC_PAR_LEN, ENC_SYM);
    localparam int BIDX_W = bidx_w_of(NBEATS);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(last_cnt_of(RSC_PAR_LEN, ENC_SYM));

    logic [1:0][VEC_W-1:0] entry;
    logic [1:0]            full, full_nxt;
    logic                  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [BIDX_W-1:0]     beat_idx, beat_idx_nxt;
    logic                  wr_fire, rd_fire, drain;
    logic [VEC_W-1:0]      sel_vec;
    logic [BEAT_W-1:0]     beat_data;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  beat_last;

    // Handshakes are functions of registered state only.
    assign par_in_ready  = !full[wr_ptr];
    assign par_out_valid = full[rd_ptr];

    // Next-state: pointer/beat advance and occupancy; a same-cycle write and drain both land.
    always_comb begin
        wr_fire      = par_in_valid & par_in_ready;
        rd_fire      = par_out_valid & par_out_ready;
        drain        = rd_fire && (beat_idx == LAST_IDX);
        beat_idx_nxt = beat_idx;
        if (rd_fire)
            beat_idx_nxt = drain ? '0 : BIDX_W'(beat_idx + 1'b1);
        rd_ptr_nxt = rd_ptr ^ drain;
        wr_ptr_nxt = wr_ptr ^ wr_fire;
        full_nxt   = full;
        for (int i = 0; i < 2; i++) begin
            if (drain && rd_ptr == 1'(i)) full_nxt[i] = 1'b0;
            if (wr_fire && wr_ptr == 1'(i)) full_nxt[i] = 1'b1;
        end
        // The head entry may be the one being written this very cycle.
        sel_vec = (wr_fire && wr_ptr == rd_ptr_nxt) ? par_in_data : entry[rd_ptr_nxt];
    end

    enc_par_beat_sel #(
        .EGF_DIM     (EGF_DIM),
        .RSC_PAR_LEN (RSC_PAR_LEN),
        .ENC_SYM     (ENC_SYM),
        .BIDX_W      (BIDX_W)
    ) u_beat_sel (
        .vec      (sel_vec),
        .beat_idx (beat_idx_nxt),
        .data     (beat_data),
        .cnt      (beat_cnt),
        .last     (beat_last)
    );

    // State and output registers; outputs preload the beat the next state will present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry        <= '0;
            full         <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            beat_idx     <= '0;
            par_out_data <= '0;
            par_out_cnt  <= '0;
            par_out_last <= 1'b0;
        end else begin
            if (wr_fire) entry[wr_ptr] <= par_in_data;
            full     <= full_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            beat_idx <= beat_idx_nxt;
            if (full_nxt[rd_ptr_nxt]) begin
                par_out_data <= beat_data;
                par_out_cnt  <= beat_cnt;
                par_out_last <= beat_last;
            end else begin
                par_out_data <= '0;
                par_out_cnt  <= '0;
                par_out_last <= 1'b0;
            end
        end
    end

    a_no_overwrite: assert property (@(posedge clk) disable iff (rst) !(wr_fire && full[wr_ptr]));
    a_cnt_nonzero:  assert property (@(posedge clk) disable iff (rst) par_out_valid |-> par_out_cnt != '0);
    a_last_cnt:     assert property (@(posedge clk) disable iff (rst) par_out_last |-> par_out_cnt == CNT_LAST);

endmodule
